// File: rtl/coconut_pkg.sv
// Shared types and constants for the coconut share-puzzle search controller.
package coconut_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int NSAILORS_DEF = 5;

    // Smallest pile that survives n night rounds plus the morning split: n^(n+1) - n + 1.
    function automatic longint unsigned coconut_solution(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i <= n; i++) r = r * longint'(n);
        return r - longint'(n) + 1;
    endfunction

endpackage

// File: rtl/coconut_round.sv
// One sailor share round: checks pile mod N == 1 and computes the pile left after the share.
module coconut_round #(
    parameter int W        = 32,
    parameter int NSAILORS = 5
) (
    input  logic [W-1:0] pile_in,
    output logic         ok,
    output logic [W-1:0] pile_out
);

    localparam logic [W-1:0] NS  = W'(NSAILORS);
    localparam logic [W-1:0] NM1 = W'(NSAILORS - 1);

    logic [W-1:0] share;

    // pile_in == 0 wraps here, but ok is low then so pile_out is never used.
    assign share    = (pile_in - W'(1)) / NS;
    assign ok       = (pile_in % NS) == W'(1);
    assign pile_out = share * NM1;

endmodule

// File: rtl/coconut_search_ctrl.sv
// Walks candidate pile sizes from start_n to limit_n, one share round per clock,
// and reports the first pile that survives every round.
module coconut_search_ctrl
    import coconut_pkg::*;
#(
    parameter int W        = 32,
    parameter int NSAILORS = NSAILORS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] start_n,
    input  logic [W-1:0] limit_n,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [W-1:0] result,
    output logic [W-1:0] cand
);

    localparam int RW = $clog2(NSAILORS + 1);

    state_t        state;
    logic [W-1:0]  pile;
    logic [W-1:0]  limit;
    logic [RW-1:0] round;
    logic          ok;
    logic [W-1:0]  pile_nx;

    coconut_round #(.W(W), .NSAILORS(NSAILORS)) u_round (
        .pile_in  (pile),
        .ok       (ok),
        .pile_out (pile_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            result <= '0;
            cand   <= '0;
            pile   <= '0;
            limit  <= '0;
            round  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        limit  <= limit_n;
                        found  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        if (start_n > limit_n) begin
                            state <= DONE;
                        end else begin
                            cand  <= start_n;
                            pile  <= start_n;
                            round <= '0;
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        found  <= 1'b0;
                        result <= '0;
                    end else if (ok && round != RW'(NSAILORS)) begin
                        pile  <= pile_nx;
                        round <= round + RW'(1);
                    end else if (ok) begin
                        found  <= 1'b1;
                        result <= cand;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cand == limit || cand == '1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cand  <= cand + W'(1);
                        pile  <= cand + W'(1);
                        round <= '0;
                    end
                end
                DONE: begin
                    // An empty range arrives here still busy; spend one cycle arming the pulse.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coconut_search_ctrl.sv
// Bench for coconut_search_ctrl: per-cycle compare against a candidate-schedule model.
module tb_coconut_search_ctrl;
    import coconut_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start5 = 1'b0, start3 = 1'b0, abort = 1'b0;
    logic [W-1:0] start_n = '0, limit_n = '0;
    logic         busy5, done5, found5, busy3, done3, found3;
    logic [W-1:0] result5, cand5, result3, cand3;

    always #5 clk = ~clk;

    coconut_search_ctrl #(.W(W), .NSAILORS(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .abort(abort),
        .start_n(start_n), .limit_n(limit_n),
        .busy(busy5), .done(done5), .found(found5), .result(result5), .cand(cand5)
    );

    coconut_search_ctrl #(.W(W), .NSAILORS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort),
        .start_n(start_n), .limit_n(limit_n),
        .busy(busy3), .done(done3), .found(found3), .result(result3), .cand(cand3)
    );

    bit           sel3 = 1'b0;
    bit           m_chk = 1'b0;
    bit           m_busy, m_done, m_found;
    logic [W-1:0] m_result, m_cand;
    int           n_checks = 0, n_fail = 0;

    logic         o_busy, o_done, o_found;
    logic [W-1:0] o_result, o_cand;
    assign o_busy   = sel3 ? busy3   : busy5;
    assign o_done   = sel3 ? done3   : done5;
    assign o_found  = sel3 ? found3  : found5;
    assign o_result = sel3 ? result3 : result5;
    assign o_cand   = sel3 ? cand3   : cand5;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_chk) begin
            chk("busy",   W'(o_busy),  W'(m_busy));
            chk("done",   W'(o_done),  W'(m_done));
            chk("found",  W'(o_found), W'(m_found));
            chk("result", o_result,    m_result);
            chk("cand",   o_cand,      m_cand);
        end
    end

    // Number of round checks spent on pile n; pass set when it survives all of them.
    function automatic int checks(input logic [W-1:0] n, input int ns, output bit pass);
        longint unsigned p, nsu;
        p = n;
        nsu = longint'(ns);
        pass = 1'b0;
        for (int k = 0; k <= ns; k++) begin
            if (p % nsu != 1) return k + 1;
            if (k == ns) begin
                pass = 1'b1;
                return k + 1;
            end
            p = (p - 1) / nsu * (nsu - 1);
        end
        return 0;
    endfunction

    task automatic drive_start(input bit use3, input logic v);
        if (use3) start3 = v; else start5 = v;
    endtask

    task automatic run(input logic [W-1:0] s, input logic [W-1:0] l, input bit use3,
                       input int kill_at, input bit kill_rst, input bit stray,
                       output bit pass, output logic [W-1:0] res,
                       output int done_cyc, output logic [W-1:0] last);
        logic [W-1:0] q[$];
        logic [W-1:0] n;
        int           c;
        bit           p;
        pass = 1'b0;
        res  = '0;
        last = m_cand;
        if (s <= l) begin
            n = s;
            forever begin
                c = checks(n, use3 ? 3 : 5, p);
                repeat (c) q.push_back(n);
                last = n;
                if (p) begin
                    pass = 1'b1;
                    res  = n;
                    break;
                end
                if (n == l || n == '1) break;
                n++;
            end
        end
        done_cyc = (s <= l) ? q.size() + 1 : 2;

        @(posedge clk); #1;
        start_n = s;
        limit_n = l;
        drive_start(use3, 1'b1);
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            @(posedge clk); #1;
            if (stray && (cyc % 7 == 3)) begin
                start_n = 7;
                limit_n = 9;
                drive_start(use3, 1'b1);
            end else begin
                drive_start(use3, 1'b0);
            end
            if (cyc < done_cyc) begin
                m_busy = 1'b1; m_done = 1'b0; m_found = 1'b0; m_result = '0;
                if (s <= l) m_cand = q[cyc-1];
            end else begin
                m_busy = 1'b0; m_done = 1'b1; m_found = pass; m_result = res; m_cand = last;
            end
            if (cyc == kill_at) begin
                if (kill_rst) begin
                    #1 reset = 1'b1;
                    m_busy = 1'b0; m_done = 1'b0; m_found = 1'b0; m_result = '0; m_cand = '0;
                    #1;
                    chk("rst_busy",   W'(o_busy),  '0);
                    chk("rst_done",   W'(o_done),  '0);
                    chk("rst_found",  W'(o_found), '0);
                    chk("rst_result", o_result,    '0);
                    chk("rst_cand",   o_cand,      '0);
                    drive_start(use3, 1'b0);
                    repeat (2) @(posedge clk);
                    #1 reset = 1'b0;
                    repeat (2) @(posedge clk);
                end else begin
                    drive_start(use3, 1'b0);
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    m_busy = 1'b0; m_found = 1'b0; m_result = '0;
                    repeat (5) @(posedge clk);
                end
                return;
            end
        end
        @(posedge clk); #1;
        drive_start(use3, 1'b0);
        m_done = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit           pass;
        logic [W-1:0] res, last;
        int           dc;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_busy",   W'(busy5),  '0);
        chk("reset_done",   W'(done5),  '0);
        chk("reset_found",  W'(found5), '0);
        chk("reset_result", result5,    '0);
        chk("reset_cand",   cand5,      '0);
        m_busy = 1'b0; m_done = 1'b0; m_found = 1'b0; m_result = '0; m_cand = '0;
        m_chk = 1'b1;

        run(15621, 20000, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("direct_done_cyc", W'(dc), 7);
        chk("direct_model_res", res, 15621);
        chk("direct_pkg_sol", W'(coconut_solution(5)), res);
        chk("direct_dut_result", result5, 15621);
        chk("direct_dut_found", W'(found5), 1);

        run(1, 20000, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("scan_model_res", res, 15621);
        chk("scan_dut_result", result5, 15621);

        run(15622, 20000, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("nosol_model_pass", W'(pass), 0);
        chk("nosol_model_last", last, 20000);
        chk("nosol_dut_cand", cand5, 20000);
        chk("nosol_dut_result", result5, 0);

        run(31246, 31246, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("second_model_res", res, 31246);
        chk("second_done_cyc", W'(dc), 7);
        chk("second_dut_result", result5, 31246);

        run(10, 5, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("empty_done_cyc", W'(dc), 2);
        chk("empty_dut_found", W'(found5), 0);

        run(1, 20000, 1'b0, 50, 1'b0, 1'b1, pass, res, dc, last);
        chk("abort_dut_busy", W'(busy5), 0);

        run(1, 20000, 1'b0, 100, 1'b1, 1'b1, pass, res, dc, last);

        run(1, 20000, 1'b0, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("recover_dut_result", result5, 15621);
        chk("recover_dut_found", W'(found5), 1);

        // dut3 has been idle since the shared reset, so its outputs are all zero.
        sel3 = 1'b1;
        m_found = 1'b0; m_result = '0; m_cand = '0;
        run(1, 100, 1'b1, 0, 1'b0, 1'b0, pass, res, dc, last);
        chk("ns3_model_res", res, 79);
        chk("ns3_pkg_sol", W'(coconut_solution(3)), res);
        chk("ns3_dut_result", result3, 79);
        chk("ns3_dut_found", W'(found3), 1);

        m_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coconut_search_ctrl.md
Name: coconut_search_ctrl

Overview:
- Sequential search controller for the monkey/coconut share puzzle.
- Walks candidate pile sizes upward from a programmed start value and runs the sailor share rounds one per clock through a round datapath.
- Reports the first pile size that survives every round plus the morning split, or reports failure at a programmed limit.
- Sits beside the combinational allocator as its sequencer: that block answers "is N valid"; this block finds N.

Parameters:
- W, 32, width of pile/candidate values (unsigned).
- NSAILORS, 5, number of night rounds; also the share divisor. Legal range 2..9.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a search; sampled only in IDLE
- abort  in  1  cancel the running search, synchronous
- start_n  in  W  first candidate; captured on accepted start
- limit_n  in  W  last candidate to try, inclusive; captured on accepted start
- busy  out  1  high while searching
- done  out  1  one-cycle pulse when a search ends
- found  out  1  valid with done, held until next accepted start; 1 = result is a solution
- result  out  W  solution value, held with found; 0 when found=0
- cand  out  W  current candidate, for debug

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, found=0, result=0, cand=0, round=0, pile=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - start=1 captures start_n and limit_n, clears found/result, and sets busy=1.
  - If start_n > limit_n, go to DONE with found=0.
  - Otherwise set cand=pile=start_n, round=0, and go to ROUND.
- ROUND: one check per cycle.
  - ok = (pile % NSAILORS == 1).
  - ok and round < NSAILORS: pile <= (pile-1)/NSAILORS*(NSAILORS-1); round++.
  - ok and round == NSAILORS (the morning split): found=1, result=cand, go to DONE.
  - Not ok and cand == limit: found=0, go to DONE.
  - Not ok and cand == all-ones: found=0, go to DONE (no wrap).
  - Otherwise cand++, pile <= cand+1, round=0, stay in ROUND. There is no dead cycle between candidates.
- DONE: done=1 for exactly one cycle; busy=0 on that same cycle; next state IDLE.
- Latency:
  - A passing candidate costs NSAILORS+1 ROUND cycles.
  - A candidate rejected at check k costs k+1 cycles.
  - If start is sampled at cycle 0 and start_n is a solution, done is high at cycle NSAILORS+2.
- Arithmetic: unsigned W-bit. pile_out <= pile_in, so there is no overflow; the only overflow point is the cand increment, handled by the all-ones rule above.
- Simultaneous events:
  - start while busy or in DONE is ignored.
  - abort has priority over every ROUND outcome: go to IDLE, busy=0, no done pulse, found/result=0.
  - abort in IDLE or DONE has no effect; a pending done pulse still fires.
- Reset mid-search: immediate return to reset values; no done.

Decomposition:
- Shared package coconut_pkg holds:
  - the state enum (IDLE, ROUND, DONE);
  - default NSAILORS constant;
  - function for the expected solution NSAILORS^(NSAILORS+1) - NSAILORS + 1, used by the bench.
- One sub-module, coconut_round: combinational.
  - Inputs: pile_in[W].
  - Outputs: ok, pile_out[W].
  - Parameterised by NSAILORS.
  - Controller instantiates it once.

Test Plan:
- start_n=15621, limit_n=20000, start pulse at cycle 0 -> done at cycle 7; found=1, result=15621; busy high cycles 1-6.
- start_n=1, limit_n=20000 -> done once; found=1, result=15621; cand monotonic 1..15621.
- start_n=15622, limit_n=20000 -> done with found=0, result=0, final cand=20000. Then start_n=31246, limit_n=31246 -> found=1, result=31246.
- start_n=10, limit_n=5 -> done at cycle 2 (IDLE->DONE); found=0; no ROUND cycles.
- NSAILORS=3, start_n=1, limit_n=100 -> found=1, result=79.
- Mid-search disturbances, start_n=1, limit_n=20000:
  - abort at cycle 50 -> IDLE next cycle, busy=0, no done pulse.
  - start pulses while busy are ignored.
  - async reset asserted mid-cycle at cycle 100 -> all outputs 0 immediately.
  - a fresh start after reset recovers and finds 15621.
